// File: rtl/fft_stage_ctrl.sv
// Frame sequencer for one 16-sample-block FFT butterfly stage: issues NUM_BLK blocks, counts their returns.
// Define FFT_CTRL_ERR_EN to add the sticky protocol-error output err.
module fft_stage_ctrl #(
  parameter int NUM_BLK = 32,
  parameter int IW      = $clog2(NUM_BLK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          bfly_valid_in,
  input  logic          bfly_valid_out,
  output logic [IW-1:0] in_blk_idx,
  output logic [IW-1:0] out_blk_idx,
  output logic          busy,
  output logic          frame_done
`ifdef FFT_CTRL_ERR_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLK - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  // out_idx saturates at LAST_IDX, so a separate flag records that the last block itself came back
  logic          ret_last_q, ret_last_d;
  logic          ret_cnt;
  logic          ret_final;

  always_comb begin
    state_d       = state_q;
    in_idx_d      = in_idx_q;
    out_idx_d     = out_idx_q;
    ret_last_d    = ret_last_q;
    din_ready     = (state_q == RUN);
    bfly_valid_in = din_valid & (state_q == RUN);
    busy          = (state_q != IDLE);
    frame_done    = (state_q == DONE);
    ret_cnt       = bfly_valid_out && ((state_q == RUN) || (state_q == DRAIN)) && !ret_last_q;
    ret_final     = ret_cnt && (out_idx_q == LAST_IDX);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          in_idx_d   = '0;
          out_idx_d  = '0;
          ret_last_d = 1'b0;
        end
      end
      RUN: begin
        if (bfly_valid_in) begin
          if (in_idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            in_idx_d = in_idx_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (ret_last_q || ret_final) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ret_cnt) begin
      if (out_idx_q == LAST_IDX) begin
        ret_last_d = 1'b1;
      end else begin
        out_idx_d = out_idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_idx_q   <= '0;
      out_idx_q  <= '0;
      ret_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_idx_q   <= in_idx_d;
      out_idx_q  <= out_idx_d;
      ret_last_q <= ret_last_d;
    end
  end

  assign in_blk_idx  = in_idx_q;
  assign out_blk_idx = out_idx_q;

`ifdef FFT_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start && (state_q != IDLE)) begin
      err_d = 1'b1;
    end
    if (bfly_valid_out && ((state_q == IDLE) || (state_q == DONE))) begin
      err_d = 1'b1;
    end
    if (bfly_valid_out && ((state_q == RUN) || (state_q == DRAIN)) && ret_last_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
